// File: rtl/fir_mac_accumulator_if.sv
// Product-in / sample-out bundle between the tap multiplier, the MAC accumulator and the DAC side.
interface fir_mac_accumulator_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_WIDTH = 16
);
  logic signed [WIDTH-1:0]     iMul;
  logic                        iMulValid;
  logic                        iSampleStart;
  logic                        oAccReady;
  logic signed [OUT_WIDTH-1:0] oOut;
  logic                        oOutValid;
  logic                        iOutReady;
  logic                        oSat;
  logic                        oDrop;

  modport master (
    output iMul, iMulValid, iSampleStart, iOutReady,
    input  oAccReady, oOut, oOutValid, oSat, oDrop
  );

  modport slave (
    input  iMul, iMulValid, iSampleStart, iOutReady,
    output oAccReady, oOut, oOutValid, oSat, oDrop
  );
endinterface

// File: rtl/fir_mac_accumulator.sv
// Sums NUM_PROD signed products per sample, then shifts, saturates and hands off via valid/ready.
// Define FIR_ACC_ROUND_EN to round half up before the shift instead of truncating.
module fir_mac_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_PROD  = 4,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 1
) (
  input logic                  iClk12M,
  input logic                  iRst,
  fir_mac_accumulator_if.slave bus
);

  localparam int unsigned CntW = $clog2(NUM_PROD);

`ifdef FIR_ACC_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  localparam int unsigned RndBit = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_WIDTH:0] RndAdd =
      (RoundEn && (SHIFT > 0)) ? ((ACC_WIDTH + 1)'(1) << RndBit) : '0;
  localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_base, mul_ext, sum;
  logic [CntW-1:0]             cnt_q, cnt_d, cnt_base;
  logic signed [OUT_WIDTH-1:0] out_q, out_d, hold_q, hold_d, res;
  logic                        sat_q, sat_d, hold_sat_q, hold_sat_d, res_sat;
  logic                        out_valid_q, out_valid_d, drop_q, drop_d;
  logic signed [ACC_WIDTH:0]   sum_wide, scaled;
  logic                        accept, last, out_free;

  assign mul_ext  = {{(ACC_WIDTH - WIDTH){bus.iMul[WIDTH-1]}}, bus.iMul};
  // A sample-start folds into this cycle's product so it begins the new group.
  assign acc_base = bus.iSampleStart ? '0 : acc_q;
  assign cnt_base = bus.iSampleStart ? '0 : cnt_q;
  assign sum      = acc_base + mul_ext;
  assign accept   = bus.iMulValid && (state_q == StAcc);
  assign last     = accept && (cnt_base == CntW'(NUM_PROD - 1));
  assign out_free = !out_valid_q || bus.iOutReady;

  always_comb begin
    sum_wide = {sum[ACC_WIDTH-1], sum} + RndAdd;
    scaled   = sum_wide >>> SHIFT;
    res_sat  = 1'b1;
    if (scaled > SatMax) begin
      res = SatMax[OUT_WIDTH-1:0];
    end else if (scaled < SatMin) begin
      res = SatMin[OUT_WIDTH-1:0];
    end else begin
      res     = scaled[OUT_WIDTH-1:0];
      res_sat = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    sat_d       = sat_q;
    hold_d      = hold_q;
    hold_sat_d  = hold_sat_q;
    out_valid_d = out_valid_q;
    drop_d      = bus.iMulValid && (state_q == StHold);

    if (out_valid_q && bus.iOutReady) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StAcc: begin
        if (accept) begin
          if (last) begin
            acc_d = '0;
            cnt_d = '0;
            if (out_free) begin
              out_d       = res;
              sat_d       = res_sat;
              out_valid_d = 1'b1;
            end else begin
              hold_d     = res;
              hold_sat_d = res_sat;
              state_d    = StHold;
            end
          end else begin
            acc_d = sum;
            cnt_d = cnt_base + CntW'(1);
          end
        end else if (bus.iSampleStart) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StHold: begin
        // The output register is always full here; the held result replaces it on transfer.
        if (bus.iOutReady) begin
          out_d       = hold_q;
          sat_d       = hold_sat_q;
          out_valid_d = 1'b1;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      hold_q      <= '0;
      hold_sat_q  <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      hold_q      <= hold_d;
      hold_sat_q  <= hold_sat_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.oAccReady = (state_q == StAcc);
  assign bus.oOut      = out_q;
  assign bus.oOutValid = out_valid_q;
  assign bus.oSat      = sat_q;
  assign bus.oDrop     = drop_q;

endmodule
